// File: rtl/serial_addsub_panel.sv
// Bit-serial add/subtract panel: operands are entered LSB first from switches,
// one bit per debounced step press, and shown on active-low LEDs.
module serial_addsub_panel #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SW1,
  input  logic             SW2,
  input  logic             SW3,
  input  logic             SW4,
  output logic [WIDTH-1:0] LD,
  output logic             LDC,
  output logic             LDD
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(WIDTH);

  logic [3:0]       sw_meta;
  logic [3:0]       sw_sync;
  logic [DW-1:0]    deb_cnt;
  logic             acc;
  logic             acc_d;
  logic             step;

  logic [CW-1:0]    cnt;
  logic             c;
  logic             mode_l;
  logic [WIDTH-1:0] res;

  logic             a;
  logic             b;
  logic             start;
  logic             mode_eff;
  logic             c_in;
  logic             r;
  logic             c_nxt;
  logic [WIDTH-1:0] res_nxt;
  logic [CW-1:0]    cnt_nxt;

  // Two-stage synchronizer for all raw switch inputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= {SW4, SW3, SW2, SW1};
      sw_sync <= sw_meta;
    end
  end

  // Step-button debouncer: accept a level only after it has been stable long enough
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      deb_cnt <= '0;
      acc     <= 1'b0;
      acc_d   <= 1'b0;
    end else begin
      acc_d <= acc;
      if (sw_sync[2] == acc) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        acc     <= sw_sync[2];
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  assign step = acc & ~acc_d;
  assign a    = sw_sync[0];
  assign b    = sw_sync[1];

  // One full-adder / full-subtractor bit; a fresh operation starts from zero carry and result
  always_comb begin
    start    = 1'b0;
    mode_eff = mode_l;
    c_in     = c;
    r        = 1'b0;
    c_nxt    = 1'b0;
    res_nxt  = '0;
    cnt_nxt  = '0;

    start    = step && ((cnt == '0) || (cnt == CNT_DONE));
    mode_eff = start ? sw_sync[3] : mode_l;
    c_in     = start ? 1'b0 : c;
    r        = a ^ b ^ c_in;
    if (mode_eff)
      c_nxt = (~a & b) | (~a & c_in) | (b & c_in);
    else
      c_nxt = (a & b) | (a & c_in) | (b & c_in);
    res_nxt  = (start ? '0 : (res >> 1)) | (WIDTH'(r) << (WIDTH - 1));
    cnt_nxt  = start ? CW'(1) : cnt + CW'(1);
  end

  // Datapath and LED registers update only on an accepted step
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt    <= '0;
      c      <= 1'b0;
      mode_l <= 1'b0;
      res    <= '0;
      LD     <= '1;
      LDC    <= 1'b1;
      LDD    <= 1'b1;
    end else if (step) begin
      cnt    <= cnt_nxt;
      c      <= c_nxt;
      mode_l <= mode_eff;
      res    <= res_nxt;
      LD     <= ~res_nxt;
      LDC    <= ~c_nxt;
      LDD    <= ~(cnt_nxt == CNT_DONE);
    end
  end

endmodule

// File: tb/tb_serial_addsub_panel.sv
// Directed bench for serial_addsub_panel with WIDTH=4, DEBOUNCE_CYCLES=4.
module tb_serial_addsub_panel;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEB   = 4;

  logic             CLK;
  logic             RST;
  logic             SW1;
  logic             SW2;
  logic             SW3;
  logic             SW4;
  logic [WIDTH-1:0] LD;
  logic             LDC;
  logic             LDD;

  int n_cmp = 0;
  int n_bad = 0;

  serial_addsub_panel #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
    .CLK(CLK), .RST(RST), .SW1(SW1), .SW2(SW2), .SW3(SW3), .SW4(SW4),
    .LD(LD), .LDC(LDC), .LDD(LDD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic       m;
    logic [3:0] a;   // bit i is entered on press i
    logic [3:0] b;
    logic [3:0] ld;  // expected active-low result LEDs
    logic       ldc; // expected active-low carry/borrow LED
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Clean press: operands stable, SW3 held through acceptance, then released and settled
  task automatic press(input logic av, input logic bv, input logic mv);
    SW1 = av; SW2 = bv; SW4 = mv;
    repeat (3) @(posedge CLK);
    #1 SW3 = 1'b1;
    repeat (DEB + 3) @(posedge CLK);
    #1 SW3 = 1'b0;
    repeat (DEB + 4) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    vecs[0] = '{"add_5p3",   1'b0, 4'b0101, 4'b0011, 4'b0111, 1'b1};
    vecs[1] = '{"sub_3m5",   1'b1, 4'b0011, 4'b0101, 4'b0001, 1'b0};
    vecs[2] = '{"add_15p1",  1'b0, 4'b1111, 4'b0001, 4'b1111, 1'b0};
    vecs[3] = '{"add_9p9",   1'b0, 4'b1001, 4'b1001, 4'b1101, 1'b0};
    vecs[4] = '{"sub_7m2",   1'b1, 4'b0111, 4'b0010, 4'b1010, 1'b1};
    vecs[5] = '{"sub_0m1",   1'b1, 4'b0000, 4'b0001, 4'b0000, 1'b0};
    vecs[6] = '{"add_0p0",   1'b0, 4'b0000, 4'b0000, 4'b1111, 1'b1};

    SW1 = 0; SW2 = 0; SW3 = 0; SW4 = 0;
    RST = 1'b1;
    #2;
    chk("rst_ld", LD, 4'b1111);
    chk("rst_ldc", {3'b0, LDC}, 4'd1);
    chk("rst_ldd", {3'b0, LDD}, 4'd1);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(posedge CLK);
    #1;

    // Table-driven operations, each a full WIDTH-press sequence
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < WIDTH; i++) begin
        press(vecs[v].a[i], vecs[v].b[i], vecs[v].m);
        chk({vecs[v].name, "_ldd"}, {3'b0, LDD}, (i == WIDTH - 1) ? 4'd0 : 4'd1);
      end
      chk({vecs[v].name, "_ld"}, LD, vecs[v].ld);
      chk({vecs[v].name, "_ldc"}, {3'b0, LDC}, {3'b0, vecs[v].ldc});
    end

    // Press after DONE restarts at bit 0: 1+1 gives r=0, carry=1
    press(1'b1, 1'b1, 1'b0);
    chk("restart_ldd", {3'b0, LDD}, 4'd1);
    chk("restart_ld", LD, 4'b1111);
    chk("restart_ldc", {3'b0, LDC}, 4'd0);

    // Bounce rejection, then a clean hold yields exactly one step at the exact edge
    do_reset();
    SW1 = 1'b1; SW2 = 1'b0; SW4 = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    begin
      int cyc;
      int p;
      cyc = 0;
      p = 0;
      while (cyc < 40) begin
        SW3 = 1'b1;
        repeat ((p % 3) + 1) @(posedge CLK);
        #1 SW3 = 1'b0;
        repeat (((p + 1) % 3) + 1) @(posedge CLK);
        #1;
        cyc += (p % 3) + ((p + 1) % 3) + 2;
        p++;
      end
    end
    repeat (6) @(posedge CLK);
    #1;
    chk("bounce_ld", LD, 4'b1111);
    chk("bounce_ldd", {3'b0, LDD}, 4'd1);
    SW3 = 1'b1;
    repeat (DEB + 2) @(posedge CLK);
    #1 chk("hold_pre_edge_ld", LD, 4'b1111);
    @(posedge CLK);
    #1 chk("hold_step_edge_ld", LD, 4'b0111);
    repeat (20) @(posedge CLK);
    #1 chk("hold_no_repeat_ld", LD, 4'b0111);
    SW3 = 1'b0;
    repeat (DEB + 4) @(posedge CLK);
    #1 chk("release_no_step_ld", LD, 4'b0111);

    // Mode flipped to subtract after the 2nd press must not affect the add
    do_reset();
    press(1'b1, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b1);
    press(1'b0, 1'b0, 1'b1);
    chk("modechg_ld", LD, 4'b0111);
    chk("modechg_ldc", {3'b0, LDC}, 4'd1);
    chk("modechg_ldd", {3'b0, LDD}, 4'd0);

    // Asynchronous reset mid-operation, then a fresh 2+2
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b1, 1'b0);
    chk("pre_rst_ld", LD, 4'b1011);
    chk("pre_rst_ldc", {3'b0, LDC}, 4'd0);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("midrst_ld", LD, 4'b1111);
    chk("midrst_ldc", {3'b0, LDC}, 4'd1);
    chk("midrst_ldd", {3'b0, LDD}, 4'd1);
    @(posedge CLK);
    #1 RST = 1'b0;
    @(posedge CLK);
    #1;
    press(1'b0, 1'b0, 1'b0);
    chk("fresh_first_ldd", {3'b0, LDD}, 4'd1);
    press(1'b1, 1'b1, 1'b0);
    press(1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b0);
    chk("fresh_2p2_ld", LD, 4'b1011);
    chk("fresh_2p2_ldc", {3'b0, LDC}, 4'd1);
    chk("fresh_2p2_ldd", {3'b0, LDD}, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
